audio_dac_tx: RTL and testbench
===============================

# audio_dac_tx

Serial transmitter that drives a 12-bit audio sample into an external SPI-style DAC (DAC121S101-class, Pmod DA2 pinout). It is the output-side counterpart of the microphone capture path: it takes 12-bit offset-binary samples from the 20 kHz audio domain and shifts each one out as a 16-bit SYNC/SCLK/DIN frame. A one-entry pending buffer absorbs a sample that arrives mid-frame, and a saturating counter records dropped samples.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `CLK` cycles; ≥1. The default gives 12.5 MHz SCLK from 100 MHz.
- `GAP_CYCLES`, default 4: SYNC-high idle time after each frame, in `CLK` cycles; ≥1.
- `CLK`  in  1: 100 MHz system clock; the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `sample_valid`  in  1: one-cycle strobe, e.g. a 20 kHz tick; `sample` is accepted on this cycle.
- `sample`  in  12: unsigned straight-binary sample.
- `pd_mode`  in  2: DAC power-down bits, inserted as frame bits 13:12.
- `DAC_SYNC`  out  1: frame select, active low.
- `DAC_SCLK`  out  1: serial clock, idles high.
- `DAC_DIN`  out  1: serial data, MSB first.
- `busy`  out  1: high while a frame or GAP is in progress.
- `done`  out  1: one-cycle pulse on entry to GAP.
- `drop_count`  out  8: count of dropped samples; saturates at 255.

## Operation
- All outputs are registered. Reset values:
  - `DAC_SYNC`=1, `DAC_SCLK`=1, `DAC_DIN`=0
  - `busy`=0, `done`=0, `drop_count`=0
  - pending buffer empty; state IDLE.
- The frame word is {2'b00, `pd_mode`, `sample`}. Both `pd_mode` and `sample` are captured at acceptance. The word is shifted MSB first, 16 bits.
- FSM states: IDLE → SHIFT → GAP → IDLE.
  - **IDLE**: SYNC=1, SCLK=1, DIN=0.
    - If `sample_valid` is high: load it.
    - Otherwise, if pending is full: load pending and clear it.
    - On either load: go to SHIFT with bit_cnt=15, div_cnt=0.
  - **SHIFT**: SYNC=0; DIN = shift_reg[15].
    - SCLK=1 while div_cnt < `CLK_DIV`; SCLK=0 for div_cnt in `CLK_DIV`..2·`CLK_DIV`−1.
    - At div_cnt = 2·`CLK_DIV`−1: div_cnt wraps to 0 and shift_reg shifts left by 1.
    - That same cycle, bit_cnt decrements. If bit_cnt was 0, go to GAP instead.
  - **GAP**: SYNC=1, SCLK=1, DIN=0; `done` pulses on the first GAP cycle.
    - Stays for exactly `GAP_CYCLES` cycles, then goes to IDLE.
- DAC timing: the DAC samples DIN on the SCLK falling edge. DIN changes only while SCLK is high, so DIN is stable for `CLK_DIV` cycles before each falling edge.
- Pending buffer (used when `sample_valid` arrives in SHIFT or GAP):
  - Empty: store `sample`/`pd_mode` and mark full.
  - Full: overwrite (newest wins) and increment `drop_count`.
- IDLE with pending full and `sample_valid` high: the new sample is transmitted, the pending entry is discarded, and `drop_count` increments.
- `drop_count` saturates at 255. It is cleared only by `reset`.
- `busy` = (state ≠ IDLE).
- No arithmetic is done on the sample; offset-binary mic data passes through unchanged.

## Timing
- Latency: `sample_valid` at cycle t gives `DAC_SYNC`=0 and the MSB on `DAC_DIN` at t+1.
  - First SCLK falling edge at t+1+`CLK_DIV`.
- SHIFT duration: 32·`CLK_DIV` cycles (128 at default).
- Frame period, start to start with back-to-back pending: 32·`CLK_DIV` + `GAP_CYCLES` + 1 cycles (133 at default). This is well under the 5000-cycle 20 kHz period.
- Last falling edge: t + 32·`CLK_DIV` − `CLK_DIV` + 1.
- SYNC rises at t + 32·`CLK_DIV` + 1, with SCLK already high.
- `done` is asserted in the same cycle SYNC rises.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously), and a partial frame is abandoned. The first frame after release starts only on a new `sample_valid`.
- `sample_valid` in the last GAP cycle: goes to pending, is transmitted from IDLE on the next cycle, SYNC falls one cycle later.

## Test plan
- **Single frame**: reset, then `sample`=12'hA5C, `pd_mode`=0, one strobe.
  - DIN sampled at the 16 SCLK falling edges = 0000_1010_0101_1100.
  - SYNC low for exactly 128 cycles; `done` pulses once; `busy` is high for 132 cycles.
- **Power-down bits**: `pd_mode`=2'b11, `sample`=12'h000.
  - Falling-edge bits = 0011_0000_0000_0000.
- **Pending**: strobe 12'h111, then 12'h222 at cycle +50.
  - Two frames; the second SYNC falls 133 cycles after the first; `drop_count`=0.
- **Overflow**: strobes 12'h111, 12'h222, 12'h333 within one frame.
  - Frames carry 111 then 333; `drop_count`=1.
  - 300 further overlapping pairs leave `drop_count`=255.
- **Reset mid-frame**: assert `reset` at SHIFT cycle 60.
  - Same cycle: SYNC=1, SCLK=1, DIN=0, `busy`=0, `drop_count`=0.
  - No frame after release until the next strobe.
- **Parameter sweep**: `CLK_DIV`=1, `GAP_CYCLES`=1, `sample`=12'hFFF.
  - SHIFT lasts 32 cycles; bits = 0000_1111_1111_1111; start-to-start 34 cycles.

Source files
------------

// File: rtl/audio_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_dac_tx
// Brief    : Serial transmitter for a 12-bit SPI-style audio DAC (SYNC/SCLK/
//            DIN, 16-bit frame). It has a one-entry pending buffer for samples
//            that arrive during a frame, and a saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module audio_dac_tx #(
    parameter int CLK_DIV    = 4,   // SCLK half-period in CLK cycles, >= 1
    parameter int GAP_CYCLES = 4    // SYNC-high idle after each frame, >= 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic [1:0]  pd_mode,
    output logic        DAC_SYNC,
    output logic        DAC_SCLK,
    output logic        DAC_DIN,
    output logic        busy,
    output logic        done,
    output logic [7:0]  drop_count
);

    localparam int c_DIV_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state,     w_state_n;
    logic [c_DIV_W-1:0] r_div_cnt,   w_div_cnt_n;
    logic [3:0]         r_bit_cnt,   w_bit_cnt_n;
    logic [c_GAP_W-1:0] r_gap_cnt,   w_gap_cnt_n;
    logic [15:0]        r_shift,     w_shift_n;
    logic               r_pend_full, w_pend_full_n;
    logic [13:0]        r_pend_word, w_pend_word_n;
    logic [7:0]         r_drop,      w_drop_n;
    logic               r_sync,      w_sync_n;
    logic               r_sclk,      w_sclk_n;
    logic               r_din,       w_din_n;
    logic               r_busy,      w_busy_n;
    logic               r_done,      w_done_n;
    logic               w_drop_inc;
    logic [15:0]        w_in_word;

    assign w_in_word = {2'b00, pd_mode, sample};

    // State, datapath and output registers; outputs hold the values the
    // next state will drive, so every pin comes straight from a flop.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_shift     <= '0;
            r_pend_full <= 1'b0;
            r_pend_word <= '0;
            r_drop      <= '0;
            r_sync      <= 1'b1;
            r_sclk      <= 1'b1;
            r_din       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_div_cnt   <= w_div_cnt_n;
            r_bit_cnt   <= w_bit_cnt_n;
            r_gap_cnt   <= w_gap_cnt_n;
            r_shift     <= w_shift_n;
            r_pend_full <= w_pend_full_n;
            r_pend_word <= w_pend_word_n;
            r_drop      <= w_drop_n;
            r_sync      <= w_sync_n;
            r_sclk      <= w_sclk_n;
            r_din       <= w_din_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
        end
    end

    // Next-state, pending-buffer and registered-output computation.
    always_comb begin
        w_state_n     = r_state;
        w_div_cnt_n   = r_div_cnt;
        w_bit_cnt_n   = r_bit_cnt;
        w_gap_cnt_n   = r_gap_cnt;
        w_shift_n     = r_shift;
        w_pend_full_n = r_pend_full;
        w_pend_word_n = r_pend_word;
        w_done_n      = 1'b0;
        w_drop_inc    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sample_valid) begin
                    // A fresh strobe wins over a waiting entry, which is lost.
                    w_shift_n     = w_in_word;
                    w_state_n     = S_SHIFT;
                    w_bit_cnt_n   = 4'd15;
                    w_div_cnt_n   = '0;
                    w_pend_full_n = 1'b0;
                    w_drop_inc    = r_pend_full;
                end else if (r_pend_full) begin
                    w_shift_n     = {2'b00, r_pend_word};
                    w_state_n     = S_SHIFT;
                    w_bit_cnt_n   = 4'd15;
                    w_div_cnt_n   = '0;
                    w_pend_full_n = 1'b0;
                end
            end
            S_SHIFT: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_div_cnt_n = '0;
                    w_shift_n   = {r_shift[14:0], 1'b0};
                    if (r_bit_cnt == 4'd0) begin
                        w_state_n   = S_GAP;
                        w_gap_cnt_n = '0;
                        w_done_n    = 1'b1;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt - 4'd1;
                    end
                end else begin
                    w_div_cnt_n = r_div_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_gap_cnt_n = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Strobes during a frame or gap park in the pending slot, newest wins.
        if (sample_valid && (r_state != S_IDLE)) begin
            w_pend_word_n = {pd_mode, sample};
            w_pend_full_n = 1'b1;
            w_drop_inc    = r_pend_full;
        end

        w_drop_n = (w_drop_inc && (r_drop != 8'hFF)) ? r_drop + 8'd1 : r_drop;

        // SCLK low only in the second half of each bit so DIN, which moves at
        // the bit boundary, is stable across the falling edge.
        w_sync_n = (w_state_n != S_SHIFT);
        w_sclk_n = !((w_state_n == S_SHIFT) && (w_div_cnt_n >= c_DIV_HALF));
        w_din_n  = (w_state_n == S_SHIFT) ? w_shift_n[15] : 1'b0;
        w_busy_n = (w_state_n != S_IDLE);
    end

    assign DAC_SYNC   = r_sync;
    assign DAC_SCLK   = r_sclk;
    assign DAC_DIN    = r_din;
    assign busy       = r_busy;
    assign done       = r_done;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_dac_tx
// Brief    : Directed self-checking bench for audio_dac_tx (default timing
//            instance plus a CLK_DIV=1 / GAP_CYCLES=1 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_dac_tx;

    logic        CLK = 1'b0;
    logic        reset;
    logic        valid0, valid1;
    logic [11:0] sample0, sample1;
    logic [1:0]  pd0, pd1;
    logic        sync0, sclk0, din0, busy0, done0;
    logic        sync1, sclk1, din1, busy1, done1;
    logic [7:0]  drop0, drop1;

    always #5 CLK = ~CLK;

    audio_dac_tx dut0 (
        .CLK(CLK), .reset(reset), .sample_valid(valid0), .sample(sample0),
        .pd_mode(pd0), .DAC_SYNC(sync0), .DAC_SCLK(sclk0), .DAC_DIN(din0),
        .busy(busy0), .done(done0), .drop_count(drop0)
    );

    audio_dac_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
        .CLK(CLK), .reset(reset), .sample_valid(valid1), .sample(sample1),
        .pd_mode(pd1), .DAC_SYNC(sync1), .DAC_SCLK(sclk1), .DAC_DIN(din1),
        .busy(busy1), .done(done1), .drop_count(drop1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line monitors: record SYNC fall times, SYNC-low length and the word
    // built from DIN sampled at each SCLK falling edge inside a frame.
    bit          p_sync0 = 1'b1, p_sclk0 = 1'b1;
    logic [15:0] bits0 = '0;
    int          nbits0 = 0;
    int          falls0[$], lows0[$], edges0[$];
    logic [15:0] frames0[$];
    int          ndone0 = 0, nbusy0 = 0, done_rise0 = 0;

    bit          p_sync1 = 1'b1, p_sclk1 = 1'b1;
    logic [15:0] bits1 = '0;
    int          falls1[$], lows1[$];
    logic [15:0] frames1[$];
    int          ndone1 = 0;

    always @(negedge CLK) begin
        if (p_sync0 && !sync0) begin
            falls0.push_back(cyc);
            bits0  = '0;
            nbits0 = 0;
        end
        if (!sync0 && p_sclk0 && !sclk0) begin
            bits0 = {bits0[14:0], din0};
            nbits0++;
        end
        if (!p_sync0 && sync0) begin
            frames0.push_back(bits0);
            edges0.push_back(nbits0);
            lows0.push_back(falls0.size() > 0 ? cyc - falls0[falls0.size()-1] : -1);
            if (done0) done_rise0++;
        end
        if (done0) ndone0++;
        if (busy0) nbusy0++;
        p_sync0 = sync0;
        p_sclk0 = sclk0;

        if (p_sync1 && !sync1) begin
            falls1.push_back(cyc);
            bits1 = '0;
        end
        if (!sync1 && p_sclk1 && !sclk1) bits1 = {bits1[14:0], din1};
        if (!p_sync1 && sync1) begin
            frames1.push_back(bits1);
            lows1.push_back(falls1.size() > 0 ? cyc - falls1[falls1.size()-1] : -1);
        end
        if (done1) ndone1++;
        p_sync1 = sync1;
        p_sclk1 = sclk1;
    end

    function automatic int fr0(input int i); return (i < frames0.size()) ? int'(frames0[i]) : -1; endfunction
    function automatic int fl0(input int i); return (i < falls0.size())  ? falls0[i] : -1;        endfunction
    function automatic int lw0(input int i); return (i < lows0.size())   ? lows0[i]  : -1;        endfunction
    function automatic int ed0(input int i); return (i < edges0.size())  ? edges0[i] : -1;        endfunction
    function automatic int fr1(input int i); return (i < frames1.size()) ? int'(frames1[i]) : -1; endfunction
    function automatic int fl1(input int i); return (i < falls1.size())  ? falls1[i] : -1;        endfunction
    function automatic int lw1(input int i); return (i < lows1.size())   ? lows1[i]  : -1;        endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Strobe held for exactly one CLK; returns #1 after the accepting edge.
    task automatic strobe0(input logic [11:0] s, input logic [1:0] pd);
        valid0 = 1'b1; sample0 = s; pd0 = pd;
        @(posedge CLK); #1;
        valid0 = 1'b0;
    endtask

    task automatic strobe1(input logic [11:0] s, input logic [1:0] pd);
        valid1 = 1'b1; sample1 = s; pd1 = pd;
        @(posedge CLK); #1;
        valid1 = 1'b0;
    endtask

    int bf, bs, nd, nb, dr;

    initial begin
        reset = 1'b1; valid0 = 1'b0; sample0 = '0; pd0 = '0;
        valid1 = 1'b0; sample1 = '0; pd1 = '0;
        wait_cycles(3);
        check_eq("rst_sync", sync0, 1); check_eq("rst_sclk", sclk0, 1);
        check_eq("rst_din",  din0,  0); check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0); check_eq("rst_drop", drop0, 0);
        reset = 1'b0;
        wait_cycles(2);

        // Single frame, A5C with pd 0
        bf = falls0.size(); bs = frames0.size(); nd = ndone0; nb = nbusy0; dr = done_rise0;
        strobe0(12'hA5C, 2'b00);
        check_eq("lat_sync", sync0, 0);
        check_eq("lat_sclk", sclk0, 1);
        check_eq("lat_busy", busy0, 1);
        wait_cycles(3);
        check_eq("pre_fall_sclk", sclk0, 1);
        wait_cycles(1);
        check_eq("first_fall_sclk", sclk0, 0);
        wait_cycles(300);
        check_eq("single_nframes", frames0.size() - bs, 1);
        check_eq("single_word", fr0(bs), 32'h0A5C);
        check_eq("single_edges", ed0(bs), 16);
        check_eq("single_sync_low", lw0(bs), 128);
        check_eq("single_done_cnt", ndone0 - nd, 1);
        check_eq("done_with_sync_rise", done_rise0 - dr, 1);
        check_eq("single_busy_cycles", nbusy0 - nb, 132);

        // Power-down bits
        bs = frames0.size();
        strobe0(12'h000, 2'b11);
        wait_cycles(300);
        check_eq("pd_word", fr0(bs), 32'h3000);

        // Pending: second strobe 50 cycles into the first frame
        bs = frames0.size(); bf = falls0.size();
        strobe0(12'h111, 2'b00);
        wait_cycles(49);
        strobe0(12'h222, 2'b00);
        wait_cycles(400);
        check_eq("pend_nframes", frames0.size() - bs, 2);
        check_eq("pend_word0", fr0(bs), 32'h0111);
        check_eq("pend_word1", fr0(bs + 1), 32'h0222);
        check_eq("pend_period", fl0(bf + 1) - fl0(bf), 133);
        check_eq("pend_drop", drop0, 0);

        // Strobe in the IDLE cycle while pending is full: new one sent, old lost
        bs = frames0.size(); bf = falls0.size();
        strobe0(12'h444, 2'b00);
        wait_cycles(20);
        strobe0(12'h555, 2'b00);
        wait_cycles(111);
        strobe0(12'h666, 2'b00);
        wait_cycles(400);
        check_eq("idlepend_nframes", frames0.size() - bs, 2);
        check_eq("idlepend_word0", fr0(bs), 32'h0444);
        check_eq("idlepend_word1", fr0(bs + 1), 32'h0666);
        check_eq("idlepend_period", fl0(bf + 1) - fl0(bf), 133);
        check_eq("idlepend_drop", drop0, 1);

        // Strobe in the last GAP cycle goes through pending
        bs = frames0.size(); bf = falls0.size();
        strobe0(12'h777, 2'b01);
        wait_cycles(131);
        strobe0(12'h888, 2'b10);
        wait_cycles(400);
        check_eq("lastgap_word0", fr0(bs), 32'h1777);
        check_eq("lastgap_word1", fr0(bs + 1), 32'h2888);
        check_eq("lastgap_period", fl0(bf + 1) - fl0(bf), 133);
        check_eq("lastgap_drop", drop0, 1);

        // Overflow: three strobes within one frame
        bs = frames0.size();
        strobe0(12'h111, 2'b00);
        wait_cycles(10);
        strobe0(12'h222, 2'b00);
        wait_cycles(10);
        strobe0(12'h333, 2'b00);
        wait_cycles(400);
        check_eq("ovf_nframes", frames0.size() - bs, 2);
        check_eq("ovf_word0", fr0(bs), 32'h0111);
        check_eq("ovf_word1", fr0(bs + 1), 32'h0333);
        check_eq("ovf_drop", drop0, 2);

        // Back-to-back strobes: after the first two, every strobe drops one
        for (int i = 0; i < 5; i++) begin
            strobe0(12'h100 + 12'(i), 2'b00);
            strobe0(12'h200 + 12'(i), 2'b00);
        end
        check_eq("drop_after_10", drop0, 10);
        for (int i = 0; i < 295; i++) begin
            strobe0(12'h300, 2'b00);
            strobe0(12'h400, 2'b00);
        end
        check_eq("drop_saturated", drop0, 255);
        wait_cycles(400);
        check_eq("drop_still_255", drop0, 255);

        // Reset at SHIFT cycle 60; word 0x01FF puts a 1 on DIN there (bit 8)
        strobe0(12'h1FF, 2'b00);
        wait_cycles(59);
        check_eq("mid_sync_before", sync0, 0);
        check_eq("mid_din_before", din0, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_sync", sync0, 1);
        check_eq("mid_rst_sclk", sclk0, 1);
        check_eq("mid_rst_din", din0, 0);
        check_eq("mid_rst_busy", busy0, 0);
        check_eq("mid_rst_drop", drop0, 0);
        wait_cycles(2);
        reset = 1'b0;
        bf = falls0.size();
        wait_cycles(300);
        check_eq("no_frame_after_rst", falls0.size() - bf, 0);
        check_eq("idle_after_rst_busy", busy0, 0);
        bs = frames0.size();
        strobe0(12'hABC, 2'b00);
        wait_cycles(300);
        check_eq("frame_after_rst", fr0(bs), 32'h0ABC);

        // CLK_DIV=1, GAP_CYCLES=1 instance
        bs = frames1.size(); bf = falls1.size(); nd = ndone1;
        strobe1(12'hFFF, 2'b00);
        wait_cycles(3);
        strobe1(12'h123, 2'b00);
        wait_cycles(120);
        check_eq("sweep_word0", fr1(bs), 32'h0FFF);
        check_eq("sweep_word1", fr1(bs + 1), 32'h0123);
        check_eq("sweep_sync_low", lw1(bs), 32);
        check_eq("sweep_period", fl1(bf + 1) - fl1(bf), 34);
        check_eq("sweep_done_cnt", ndone1 - nd, 2);
        check_eq("sweep_busy_end", busy1, 0);
        check_eq("sweep_drop", drop1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
